nonce_scheduler: RTL

- Sequencing controller between the block store, the pipelined SHA hasher and the nonce buffer in the miner top level.
- Accepts one block job (352-bit initial state plus a leading-zero difficulty) and sweeps 2^COUNTBITS nonces into the hasher, honouring hasher backpressure.
- Matches in-order hash results back to their nonces, checks each against the difficulty, and pushes winning nonces to the nonce buffer.
- Reports job completion and buffer overflow.

---
 rtl/nonce_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nonce_scheduler.sv
// Sweeps 2^COUNTBITS nonces of one block job into the hasher, matches in-order results to
// nonces, checks them against the difficulty and writes winning nonces to the nonce buffer.
module nonce_scheduler #(
  parameter int COUNTBITS   = 6,
  parameter bit STOP_ON_HIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [351:0] blk_state,
  input  logic [7:0]   blk_zeros,
  input  logic         abort,
  input  logic         hash_ready,
  output logic         hash_valid,
  output logic         hash_new_block,
  output logic [351:0] hash_state,
  output logic [31:0]  hash_nonce,
  input  logic         res_valid,
  input  logic [255:0] res_hash,
  output logic         nonce_valid,
  output logic [31:0]  nonce,
  input  logic         nonce_full,
  output logic         overflow,
  output logic         busy,
  output logic         done,
  output logic [7:0]   hit_count,
  output logic         protocol_err
);

  localparam int CW = COUNTBITS + 1;
  localparam logic [CW-1:0] LAST_NONCE = {1'b0, {COUNTBITS{1'b1}}};
  localparam logic [CW-1:0] CTR_ONE    = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t         r_state;
  logic [351:0]   r_job_state;
  logic [7:0]     r_zeros;
  logic [CW-1:0]  r_issue_ctr;
  logic [CW-1:0]  r_res_ctr;
  logic [CW-1:0]  r_inflight;
  logic [7:0]     r_hit_count;
  logic           r_overflow;
  logic           r_protocol_err;
  logic           r_nonce_valid;
  logic [31:0]    r_nonce;

  logic           w_active;
  logic           w_issue;
  logic           w_last_issue;
  logic           w_res_orphan;
  logic           w_res_take;
  logic           w_hit;
  logic [255:0]   w_mask;

  assign w_active     = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_issue      = (r_state == S_ISSUE) && hash_ready;
  assign w_last_issue = w_issue && (r_issue_ctr == LAST_NONCE);
  assign w_res_orphan = res_valid && (r_inflight == '0);
  assign w_res_take   = res_valid && !w_res_orphan && w_active;
  // Ones over the top r_zeros bits; r_zeros == 0 gives an empty mask so every hash hits.
  assign w_mask       = ~({256{1'b1}} >> r_zeros);
  assign w_hit        = w_res_take && ((res_hash & w_mask) == '0);

  assign blk_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign hash_valid     = (r_state == S_ISSUE);
  assign hash_new_block = (r_state == S_ISSUE) && (r_issue_ctr == '0);
  assign hash_state     = r_job_state;
  assign hash_nonce     = {{(32-CW){1'b0}}, r_issue_ctr};
  assign nonce_valid    = r_nonce_valid;
  assign nonce          = r_nonce;
  assign overflow       = r_overflow;
  assign hit_count      = r_hit_count;
  assign protocol_err   = r_protocol_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_job_state    <= '0;
      r_zeros        <= '0;
      r_issue_ctr    <= '0;
      r_res_ctr      <= '0;
      r_inflight     <= '0;
      r_hit_count    <= '0;
      r_overflow     <= 1'b0;
      r_protocol_err <= 1'b0;
      r_nonce_valid  <= 1'b0;
      r_nonce        <= '0;
    end else begin
      r_nonce_valid <= 1'b0;
      if (w_res_orphan)
        r_protocol_err <= 1'b1;
      if (w_issue)
        r_issue_ctr <= r_issue_ctr + CTR_ONE;
      if (w_res_take)
        r_res_ctr <= r_res_ctr + CTR_ONE;
      if (w_issue && !w_res_take)
        r_inflight <= r_inflight + CTR_ONE;
      else if (!w_issue && w_res_take)
        r_inflight <= r_inflight - CTR_ONE;

      if (w_hit) begin
        if (nonce_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_nonce_valid <= 1'b1;
          r_nonce       <= {{(32-CW){1'b0}}, r_res_ctr};
        end
        if (r_hit_count != 8'hFF)
          r_hit_count <= r_hit_count + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (blk_valid) begin
            r_job_state    <= blk_state;
            r_zeros        <= blk_zeros;
            r_issue_ctr    <= '0;
            r_res_ctr      <= '0;
            r_inflight     <= '0;
            r_hit_count    <= '0;
            r_overflow     <= 1'b0;
            r_protocol_err <= w_res_orphan;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_last_issue || abort || (STOP_ON_HIT && w_hit))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_inflight == '0) && !res_valid)
            r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
